// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store engine: FSM states, access sizes,
// error codes and the request legality check used at launch time.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_DONE = 2'd2,
        MAU_ERR  = 2'd3
    } mau_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Illegal size takes priority over alignment so a size-11 request never reports 01.
    function automatic logic [1:0] check_request(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] code;
        code = ERR_NONE;
        if (size == SIZE_ILL) begin
            code = ERR_ILLEGAL;
        end else if ((size == SIZE_HALF) && addr_lo[0]) begin
            code = ERR_MISALIGN;
        end else if ((size == SIZE_WORD) && (addr_lo != 2'b00)) begin
            code = ERR_MISALIGN;
        end
        return code;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering: store enables/replication and load lane extract with
// sign or zero extension. Purely combinational.
module mau_lane
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata_raw_i[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        case (size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext_i & half_sel[15]}}, half_sel};
            end
            SIZE_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_raw_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine: validates the request, runs a req/ack handshake with a
// variable-latency memory and aborts on a bus timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    mau_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              accept;
    logic [1:0]        req_code;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              in_req;

    assign req_code = check_request(size_i, addr_i[1:0]);

    mau_lane u_lane (
        .size_i      (size_q),
        .sext_i      (sext_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_raw_i (mem_rdata_i),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= MAU_IDLE;
            cnt_q      <= '0;
            err_code_q <= ERR_NONE;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= we_i;
            size_q  <= size_i;
            sext_q  <= sext_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        rdata_d    = rdata_q;
        accept     = 1'b0;
        case (state_q)
            MAU_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    err_code_d = req_code;
                    if (req_code != ERR_NONE) begin
                        state_d = MAU_ERR;
                    end else begin
                        state_d = MAU_REQ;
                        accept  = 1'b1;
                    end
                end
            end
            MAU_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the final allowed cycle still completes the access.
                if (mem_ack_i) begin
                    state_d = MAU_DONE;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdata_d = lane_rdata;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d    = MAU_ERR;
                    err_code_d = ERR_TIMEOUT;
                    cnt_d      = '0;
                end
            end
            MAU_DONE: state_d = MAU_IDLE;
            MAU_ERR:  state_d = MAU_IDLE;
            default:  state_d = MAU_IDLE;
        endcase
    end

    assign in_req      = (state_q == MAU_REQ);
    assign busy_o      = in_req;
    assign done_o      = (state_q == MAU_DONE);
    assign err_o       = (state_q == MAU_ERR);
    assign err_code_o  = err_code_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & we_q;
    assign mem_addr_o  = in_req ? addr_q[ADDR_W-1:2] : '0;
    assign mem_be_o    = in_req ? lane_be : 4'b0000;
    assign mem_wdata_o = in_req ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, random
// accesses against an arithmetic reference model, and multi-cycle corner cases.
module tb_mem_access_unit;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sext = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = 32'h0;
    logic              busy, done, err;
    logic [1:0]        err_code;
    logic [31:0]       rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .we_i(we), .size_i(size),
        .sext_i(sext), .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done),
        .err_o(err), .err_code_o(err_code), .rdata_o(rdata), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    typedef struct {
        logic              we;
        logic [1:0]        size;
        logic              sext;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       mrdata;
        int                lat;
        logic [1:0]        ecode;
        logic [3:0]        be;
        logic [31:0]       ewdata;
        logic [31:0]       erdata;
    } vec_t;

    function automatic vec_t mkv(logic w, logic [1:0] sz, logic sx, logic [ADDR_W-1:0] a,
                                 logic [31:0] wd, logic [31:0] mrd, int lat, logic [1:0] ec,
                                 logic [3:0] be, logic [31:0] ewd, logic [31:0] erd);
        vec_t v;
        v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd; v.mrdata = mrd;
        v.lat = lat; v.ecode = ec; v.be = be; v.ewdata = ewd; v.erdata = erd;
        return v;
    endfunction

    // Reference model written from the access rules with plain arithmetic.
    function automatic logic [1:0] m_code(logic [1:0] sz, logic [ADDR_W-1:0] a);
        int off = int'(a % 4);
        if (sz == 2'd3) return 2'd3;
        if (sz == 2'd1 && (off % 2) != 0) return 2'd1;
        if (sz == 2'd2 && off != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] sz, logic [ADDR_W-1:0] a);
        int off = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, logic sx, logic [ADDR_W-1:0] a, logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(a % 4));
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (sx && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (sx && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        start = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    endtask

    task automatic run_access(input string tag, input vec_t v, input bit noise);
        step();
        drive_req(v.we, v.size, v.sext, v.addr, v.wdata);
        step();
        start = 1'b0;
        if (v.ecode != 2'b00) begin
            chk({tag, " err"}, 32'(err), 32'd1);
            chk({tag, " err_code"}, 32'(err_code), 32'(v.ecode));
            chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
            chk({tag, " busy"}, 32'(busy), 32'd0);
            chk({tag, " rdata_held"}, rdata, last_rdata);
            step();
            chk({tag, " err_pulse"}, 32'(err), 32'd0);
        end else begin
            for (int c = 1; c <= v.lat; c++) begin
                chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, " busy"}, 32'(busy), 32'd1);
                chk({tag, " early_done"}, 32'(done), 32'd0);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
                if (c == 1) begin
                    chk({tag, " mem_be"}, 32'(mem_be), 32'(v.be));
                    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.addr >> 2));
                    if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.ewdata);
                end
                if (noise) begin
                    start = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
                    addr = ADDR_W'($urandom); wdata = $urandom;
                end
                if (c == v.lat) begin
                    mem_ack = 1'b1; mem_rdata = v.mrdata;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                step();
            end
            mem_ack = 1'b0;
            start = 1'b0;
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " busy_after"}, 32'(busy), 32'd0);
            chk({tag, " req_after"}, 32'(mem_req), 32'd0);
            chk({tag, " err_code_clr"}, 32'(err_code), 32'd0);
            if (!v.we) last_rdata = v.erdata;
            chk({tag, " rdata"}, rdata, last_rdata);
            step();
            chk({tag, " done_pulse"}, 32'(done), 32'd0);
        end
        $display("%s we=%0d size=%0d sext=%0d addr=0x%04h wdata=0x%08h mrdata=0x%08h lat=%0d code=%0d rdata=0x%08h",
                 tag, v.we, v.size, v.sext, v.addr, v.wdata, v.mrdata, v.lat, v.ecode, rdata);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " err_code"}, 32'(err_code), 32'd0);
        chk({tag, " rdata"}, rdata, 32'd0);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " mem_bus"}, {mem_we, mem_be, 27'(mem_addr)}, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = mkv(1'b0, 2'b00, 1'b1, 14'h0001, 32'h0,        32'h8899AABB, 2, 2'b00, 4'b0010, 32'h0,        32'hFFFFFFAA);
        vecs[1]  = mkv(1'b1, 2'b01, 1'b0, 14'h0002, 32'h00001234, 32'h0,        3, 2'b00, 4'b1100, 32'h12341234, 32'h0);
        vecs[2]  = mkv(1'b0, 2'b10, 1'b0, 14'h0006, 32'h0,        32'h0,        1, 2'b01, 4'b0000, 32'h0,        32'h0);
        vecs[3]  = mkv(1'b0, 2'b11, 1'b0, 14'h0000, 32'h0,        32'h0,        1, 2'b11, 4'b0000, 32'h0,        32'h0);
        vecs[4]  = mkv(1'b0, 2'b01, 1'b1, 14'h0003, 32'h0,        32'h0,        1, 2'b01, 4'b0000, 32'h0,        32'h0);
        vecs[5]  = mkv(1'b1, 2'b00, 1'b0, 14'h0103, 32'hCAFE00A5, 32'h0,        1, 2'b00, 4'b1000, 32'hA5A5A5A5, 32'h0);
        vecs[6]  = mkv(1'b0, 2'b01, 1'b1, 14'h0010, 32'h0,        32'h12348001, 4, 2'b00, 4'b0011, 32'h0,        32'hFFFF8001);
        vecs[7]  = mkv(1'b0, 2'b00, 1'b0, 14'h0003, 32'h0,        32'hF0000000, 1, 2'b00, 4'b1000, 32'h0,        32'h000000F0);
        vecs[8]  = mkv(1'b0, 2'b10, 1'b1, 14'h3FFC, 32'h0,        32'h80000000, 5, 2'b00, 4'b1111, 32'h0,        32'h80000000);
        vecs[9]  = mkv(1'b1, 2'b10, 1'b0, 14'h0004, 32'hDEADBEEF, 32'h0,        2, 2'b00, 4'b1111, 32'hDEADBEEF, 32'h0);
        vecs[10] = mkv(1'b0, 2'b01, 1'b1, 14'h0002, 32'h0,        32'hFFFE1234, 2, 2'b00, 4'b1100, 32'h0,        32'hFFFFFFFE);
        vecs[11] = mkv(1'b0, 2'b00, 1'b1, 14'h0002, 32'h0,        32'h007F0000, 1, 2'b00, 4'b0100, 32'h0,        32'h0000007F);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Timeout: mem_req for cycles 1..8, err at 9, late ack at 10 ignored.
        step();
        drive_req(1'b0, 2'b10, 1'b0, 14'h0008, 32'h0);
        step();
        start = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            chk($sformatf("timeout req c%0d", c), 32'(mem_req), 32'd1);
            step();
        end
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout code", 32'(err_code), 32'd2);
        chk("timeout req_drop", 32'(mem_req), 32'd0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        chk("timeout err_pulse", 32'(err), 32'd0);
        step();
        mem_ack = 1'b0;
        chk("late_ack done", 32'(done), 32'd0);
        chk("late_ack busy", 32'(busy), 32'd0);
        chk("late_ack code_held", 32'(err_code), 32'd2);
        chk("late_ack rdata", rdata, last_rdata);
        $display("timeout sequence code=%0d", err_code);

        // Asynchronous reset in the third REQ cycle.
        step();
        drive_req(1'b0, 2'b10, 1'b0, 14'h0020, 32'h0);
        step();
        start = 1'b0;
        step();
        step();
        chk("rst_mid req", 32'(mem_req), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        last_rdata = 32'h0;
        step();
        chk("rst_after done", 32'(done), 32'd0);
        chk("rst_after err", 32'(err), 32'd0);
        chk("rst_after busy", 32'(busy), 32'd0);
        $display("reset sequence rdata=0x%08h", rdata);
        run_access("post_rst", mkv(1'b0, 2'b01, 1'b0, 14'h0002, 32'h0, 32'hBEEF0000, 2,
                                   2'b00, 4'b1100, 32'h0, 32'h0000BEEF), 1'b0);

        // Back-to-back: ack on the first REQ cycle, start held from DONE into IDLE.
        step();
        drive_req(1'b0, 2'b00, 1'b0, 14'h0021, 32'h0);
        step();
        start = 1'b0;
        chk("b2b req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0000C300;
        step();
        mem_ack = 1'b0;
        chk("b2b done", 32'(done), 32'd1);
        chk("b2b rdata", rdata, 32'h000000C3);
        drive_req(1'b1, 2'b10, 1'b0, 14'h0040, 32'h55AA55AA);
        step();
        chk("b2b ignored busy", 32'(busy), 32'd0);
        chk("b2b ignored req", 32'(mem_req), 32'd0);
        step();
        start = 1'b0;
        chk("b2b accepted req", 32'(mem_req), 32'd1);
        chk("b2b accepted we", 32'(mem_we), 32'd1);
        chk("b2b accepted wdata", mem_wdata, 32'h55AA55AA);
        chk("b2b accepted addr", 32'(mem_addr), 32'h10);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b2b second done", 32'(done), 32'd1);
        chk("b2b rdata_held", rdata, 32'h000000C3);
        last_rdata = 32'h000000C3;
        step();
        $display("back-to-back sequence done");

        // Random accesses against the reference model, with start noise during REQ.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.we     = 1'($urandom);
            v.size   = 2'($urandom_range(0, 3));
            v.sext   = 1'($urandom);
            v.addr   = ADDR_W'($urandom);
            v.wdata  = $urandom;
            v.mrdata = $urandom;
            v.lat    = int'($urandom_range(1, 6));
            v.ecode  = m_code(v.size, v.addr);
            v.be     = m_be(v.size, v.addr);
            v.ewdata = m_wdata(v.size, v.wdata);
            v.erdata = m_load(v.size, v.sext, v.addr, v.mrdata);
            run_access($sformatf("rand%0d", i), v, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
